// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Shares port A of a block RAM between two requesters: requester 0 is the
//   parser-side writer and requester 1 is the readout/host side. Arbitration
//   is round-robin when the port is free. A requester can lock the port to
//   itself for read-modify-write sequences. Read data is returned one cycle
//   after the grant and is tagged back to the requester that issued the read.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   req_n, we_n         requester n wants one access; 1 = write, 0 = read
//   lock_n              keep the port for requester n after this access
//   addr_n, wdata_n     access address and write data
//   gnt_n               access accepted this cycle (combinational)
//   rvalid_n, rdata_n   read return for requester n (rdata_n is ram_dout)
//   ram_en, ram_we      RAM port enable and write enable
//   ram_addr, ram_din   RAM address and write data
//   ram_dout            RAM read data, one cycle after ram_en
module bram_port_arbiter #(
  parameter int WORDSIZE  = 8,
  parameter int ADDRWIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_0,
  input  logic                 we_0,
  input  logic                 lock_0,
  input  logic [ADDRWIDTH-1:0] addr_0,
  input  logic [WORDSIZE-1:0]  wdata_0,
  input  logic                 req_1,
  input  logic                 we_1,
  input  logic                 lock_1,
  input  logic [ADDRWIDTH-1:0] addr_1,
  input  logic [WORDSIZE-1:0]  wdata_1,
  output logic                 gnt_0,
  output logic                 gnt_1,
  output logic                 rvalid_0,
  output logic                 rvalid_1,
  output logic [WORDSIZE-1:0]  rdata_0,
  output logic [WORDSIZE-1:0]  rdata_1,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [WORDSIZE-1:0]  ram_din,
  input  logic [WORDSIZE-1:0]  ram_dout
);

  localparam logic [1:0] FREE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       prio;
  logic       pending;
  logic       tag;
  logic       allow0;
  logic       allow1;

  // Grant: the state must admit the requester, and in FREE with both
  // asking only the prio side wins. rst masks all grants combinationally.
  always_comb begin
    allow0 = (state == FREE) || (state == LOCK0);
    allow1 = (state == FREE) || (state == LOCK1);
    gnt_0  = !rst && req_0 && allow0 && !((state == FREE) && req_1 && prio);
    gnt_1  = !rst && req_1 && allow1 && !((state == FREE) && req_0 && !prio);
  end

  always_comb begin
    ram_en   = gnt_0 | gnt_1;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt_0) begin
      ram_we   = we_0;
      ram_addr = addr_0;
      ram_din  = wdata_0;
    end else if (gnt_1) begin
      ram_we   = we_1;
      ram_addr = addr_1;
      ram_din  = wdata_1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FREE: begin
        if (gnt_0 && lock_0)      state_nxt = LOCK0;
        else if (gnt_1 && lock_1) state_nxt = LOCK1;
      end
      LOCK0: begin
        // Released either by an unlocked access or by going idle unlocked.
        if (!lock_0 && (gnt_0 || !req_0)) state_nxt = FREE;
      end
      LOCK1: begin
        if (!lock_1 && (gnt_1 || !req_1)) state_nxt = FREE;
      end
      default: state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FREE;
      prio    <= 1'b0;
      pending <= 1'b0;
      tag     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt_0)      prio <= 1'b1;
      else if (gnt_1) prio <= 1'b0;
      pending <= (gnt_0 && !we_0) || (gnt_1 && !we_1);
      tag     <= gnt_1;
    end
  end

  assign rvalid_0 = pending && !tag;
  assign rvalid_1 = pending && tag;
  assign rdata_0  = ram_dout;
  assign rdata_1  = ram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
//   Directed-vector bench for bram_port_arbiter with a small write-first RAM
//   model attached to the RAM port. Expected values are hand-computed.
module tb_bram_port_arbiter;

  localparam int WS = 8;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_0, we_0, lock_0, req_1, we_1, lock_1;
  logic [AW-1:0] addr_0, addr_1;
  logic [WS-1:0] wdata_0, wdata_1;
  logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [WS-1:0] rdata_0, rdata_1;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [WS-1:0] ram_din;
  logic [WS-1:0] ram_dout;

  logic [WS-1:0] mem [0:(1<<AW)-1];

  int vectors = 0;
  int miscompares = 0;

  bram_port_arbiter #(.WORDSIZE(WS), .ADDRWIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .we_0(we_0), .lock_0(lock_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .req_1(req_1), .we_1(we_1), .lock_1(lock_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Write-first single-port RAM
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_din;
        ram_dout      <= ram_din;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    req_0 = 0; we_0 = 0; lock_0 = 0; addr_0 = '0; wdata_0 = '0;
    req_1 = 0; we_1 = 0; lock_1 = 0; addr_1 = '0; wdata_1 = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[5]   = 8'h3C;
    ram_dout = '0;
    idle();
    rst = 1'b1;
    req_0 = 1; we_0 = 1;

    // Reset: grants and RAM controls masked even with a request present
    @(negedge clk);
    check("rst_gnt0", gnt_0, 0);
    check("rst_en", ram_en, 0);
    check("rst_we", ram_we, 0);
    check("rst_rvalid0", rvalid_0, 0);
    check("rst_rvalid1", rvalid_1, 0);
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("idle_en", ram_en, 0);
    check("idle_addr", ram_addr, 0);
    check("idle_din", ram_din, 0);
    next_cycle();

    // Read addr 5 by requester 0
    req_0 = 1; addr_0 = 9'd5;
    @(negedge clk);
    check("rd5_gnt0", gnt_0, 1);
    check("rd5_gnt1", gnt_1, 0);
    check("rd5_en", ram_en, 1);
    check("rd5_addr", ram_addr, 5);
    check("rd5_we", ram_we, 0);
    next_cycle();
    // Return cycle; requester 1 writes so prio points back to 0
    idle();
    req_1 = 1; we_1 = 1; addr_1 = 9'd10; wdata_1 = 8'h11;
    @(negedge clk);
    check("rd5_rvalid0", rvalid_0, 1);
    check("rd5_rvalid1", rvalid_1, 0);
    check("rd5_rdata0", rdata_0, 8'h3C);
    check("wr10_gnt1", gnt_1, 1);
    next_cycle();

    // Fairness: both reading continuously
    idle();
    req_0 = 1; req_1 = 1; addr_0 = 9'd5; addr_1 = 9'd10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("fair_gnt0", gnt_0, (i % 2 == 0) ? 1 : 0);
      check("fair_gnt1", gnt_1, (i % 2 == 1) ? 1 : 0);
      check("fair_en", ram_en, 1);
      if (i > 0) begin
        check("fair_rv0", rvalid_0, (i % 2 == 1) ? 1 : 0);
        check("fair_rv1", rvalid_1, (i % 2 == 0) ? 1 : 0);
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    check("fair_last_rv1", rvalid_1, 1);
    check("fair_last_rd1", rdata_1, 8'h11);
    next_cycle();

    // Write by 0 then read of the same address by 1
    req_0 = 1; we_0 = 1; addr_0 = 9'd3; wdata_0 = 8'hA5;
    @(negedge clk);
    check("wr3_gnt0", gnt_0, 1);
    check("wr3_we", ram_we, 1);
    check("wr3_din", ram_din, 8'hA5);
    next_cycle();
    idle();
    req_1 = 1; addr_1 = 9'd3;
    @(negedge clk);
    check("rd3_gnt1", gnt_1, 1);
    check("rd3_rv0_wr", rvalid_0, 0);
    next_cycle();
    idle();
    @(negedge clk);
    check("rd3_rv1", rvalid_1, 1);
    check("rd3_rdata1", rdata_1, 8'hA5);
    check("rd3_rv0", rvalid_0, 0);
    next_cycle();

    // Lone write by 0 so prio points at requester 1
    req_0 = 1; we_0 = 1; addr_0 = 9'd20; wdata_0 = 8'h01;
    @(negedge clk);
    check("wr20_gnt0", gnt_0, 1);
    next_cycle();

    // Requester 1 locks for read-modify-write of addr 7, 0 keeps asking
    idle();
    req_0 = 1; addr_0 = 9'd5;
    req_1 = 1; lock_1 = 1; addr_1 = 9'd7;
    @(negedge clk);
    check("lk_rd_gnt1", gnt_1, 1);
    check("lk_rd_gnt0", gnt_0, 0);
    next_cycle();
    we_1 = 1; lock_1 = 0; wdata_1 = 8'h5A;
    @(negedge clk);
    check("lk_wr_gnt1", gnt_1, 1);
    check("lk_wr_gnt0", gnt_0, 0);
    check("lk_wr_addr", ram_addr, 7);
    check("lk_rv1", rvalid_1, 1);
    next_cycle();
    req_1 = 0; we_1 = 0;
    @(negedge clk);
    check("lk_after_gnt0", gnt_0, 1);
    next_cycle();

    // Read by 0 (prio now 1 -> after this grant still 1), reset during return
    idle();
    req_0 = 1; addr_0 = 9'd5;
    @(negedge clk);
    check("ar_gnt0", gnt_0, 1);
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    #1;
    check("ar_rv0_in_rst", rvalid_0, 0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ar_rv0", rvalid_0, 0);
    check("ar_rv1", rvalid_1, 0);
    next_cycle();

    // prio back to 0 after reset: both ask, 0 wins and takes the lock
    req_0 = 1; lock_0 = 1; addr_0 = 9'd5;
    req_1 = 1; addr_1 = 9'd10;
    @(negedge clk);
    check("pr_gnt0", gnt_0, 1);
    check("pr_gnt1", gnt_1, 0);
    next_cycle();
    // LOCK0 held without a request: requester 1 still blocked
    req_0 = 0;
    @(negedge clk);
    check("l0_hold_gnt1", gnt_1, 0);
    check("l0_rv0", rvalid_0, 1);
    check("l0_rd0", rdata_0, 8'h3C);
    next_cycle();
    // Drop lock without an access
    lock_0 = 0;
    @(negedge clk);
    check("l0_drop_gnt1", gnt_1, 0);
    next_cycle();
    @(negedge clk);
    check("l0_free_gnt1", gnt_1, 1);
    next_cycle();
    idle();
    @(negedge clk);
    check("end_rv1", rvalid_1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
